// File: rtl/reg_adder_pkg.sv
// reg_adder_pkg: sizing helper shared by the carry-lookahead adder.
package reg_adder_pkg;

   function automatic int num_groups(input int width, input int group);
      return (width + group - 1) / group;
   endfunction

endpackage

// File: rtl/reg_adder_cla_group.sv
// cla_group: N-bit carry-lookahead slice with group generate/propagate.
module cla_group
   import reg_adder_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         gg,
   output logic         gp,
   output logic         cout
);

   logic [N-1:0] g, p;
   logic [N:0]   c;
   logic         t, u;

   // each carry is expanded independently from cin, not chained bit to bit
   always_comb begin
      g = a & b;
      p = a ^ b;
      c = '0;
      t = 1'b0;
      u = 1'b0;
      for (int i = 0; i <= N; i++) begin
         t = cin;
         for (int j = 0; j < i; j++) t = g[j] | (p[j] & t);
         c[i] = t;
      end
      for (int j = 0; j < N; j++) u = g[j] | (p[j] & u);
   end

   assign sum  = p ^ c[N-1:0];
   assign gg   = u;
   assign gp   = &p;
   assign cout = c[N];

endmodule

// File: rtl/reg_adder.sv
// reg_adder: CLA adder with combinational sum/flags and a one-cycle registered copy.
module reg_adder
   import reg_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf,
   output logic [WIDTH-1:0] out_q,
   output logic             cout_q,
   output logic             ovf_q
);

   localparam int NG = num_groups(WIDTH, GROUP);

   logic [NG:0]   gc;
   logic [NG-1:0] gg, gp, sc;
   logic          unused_sc;

   assign gc[0] = 1'b0;

   for (genvar k = 0; k < NG; k++) begin : grp
      localparam int LO = k * GROUP;
      localparam int N  = (WIDTH - LO < GROUP) ? WIDTH - LO : GROUP;
      cla_group #(.N(N)) u_cla (
         .a    (in1[LO+N-1:LO]),
         .b    (in2[LO+N-1:LO]),
         .cin  (gc[k]),
         .sum  (out[LO+N-1:LO]),
         .gg   (gg[k]),
         .gp   (gp[k]),
         .cout (sc[k])
      );
      assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
   end

   // slice carries duplicate the group-level chain, which is the one used
   assign unused_sc = ^sc;

   assign cout = gc[NG];
   assign ovf  = (in1[WIDTH-1] == in2[WIDTH-1]) && (out[WIDTH-1] != in1[WIDTH-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         out_q  <= out;
         cout_q <= cout;
         ovf_q  <= ovf;
      end
   end

endmodule

// File: tb/tb_reg_adder.sv
// tb_reg_adder: random and directed checks of reg_adder at WIDTH=32 and WIDTH=13.
module tb_reg_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in1 = '0, in2 = '0, out, out_q;
   logic [12:0] s_in1 = '0, s_in2 = '0, s_out, s_out_q;
   logic        cout, ovf, cout_q, ovf_q;
   logic        s_cout, s_ovf, s_cout_q, s_ovf_q;

   logic [63:0] e_out, e_s_out;
   logic        e_cout, e_ovf, e_s_cout, e_s_ovf;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   reg_adder #(.WIDTH(32), .GROUP(4)) dut32 (
      .clk(clk), .rst(rst), .in1(in1), .in2(in2),
      .out(out), .cout(cout), .ovf(ovf),
      .out_q(out_q), .cout_q(cout_q), .ovf_q(ovf_q)
   );

   reg_adder #(.WIDTH(13), .GROUP(4)) dut13 (
      .clk(clk), .rst(rst), .in1(s_in1), .in2(s_in2),
      .out(s_out), .cout(s_cout), .ovf(s_ovf),
      .out_q(s_out_q), .cout_q(s_cout_q), .ovf_q(s_ovf_q)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference: exact integer sum, then signed range test for overflow
   function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] s, output logic c, output logic v);
      longint mask, ua, ub, full, sa, sb, ssum;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      full = ua + ub;
      s    = 64'(full & mask);
      c    = ((full >> w) & 1) != 0;
      sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
      sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
      ssum = sa + sb;
      v    = (ssum > (longint'(1) << (w - 1)) - 1) || (ssum < -(longint'(1) << (w - 1)));
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in1 = a;
      in2 = b;
      s_in1 = a[12:0];
      s_in2 = b[12:0];
      #1;
      model(32, 64'(a), 64'(b), e_out, e_cout, e_ovf);
      model(13, 64'(a), 64'(b), e_s_out, e_s_cout, e_s_ovf);
      check("out32", 64'(out), e_out);
      check("cout32", 64'(cout), 64'(e_cout));
      check("ovf32", 64'(ovf), 64'(e_ovf));
      check("out13", 64'(s_out), e_s_out);
      check("cout13", 64'(s_cout), 64'(e_s_cout));
      check("ovf13", 64'(s_ovf), 64'(e_s_ovf));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check("out_q32", 64'(out_q), e_out);
      check("cout_q32", 64'(cout_q), 64'(e_cout));
      check("ovf_q32", 64'(ovf_q), 64'(e_ovf));
      check("out_q13", 64'(s_out_q), e_s_out);
      check("cout_q13", 64'(s_cout_q), 64'(e_s_cout));
      check("ovf_q13", 64'(s_ovf_q), 64'(e_s_ovf));
   endtask

   task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eo, input logic ec, input logic ev);
      drive(a, b);
      check({tag, "_out"}, 64'(out), 64'(eo));
      check({tag, "_cout"}, 64'(cout), 64'(ec));
      check({tag, "_ovf"}, 64'(ovf), 64'(ev));
      tick();
      check({tag, "_out_q"}, 64'(out_q), 64'(eo));
      check({tag, "_cout_q"}, 64'(cout_q), 64'(ec));
   endtask

   initial begin
      #1;
      check("rst_out_q32", 64'(out_q), 64'd0);
      check("rst_cout_q32", 64'(cout_q), 64'd0);
      check("rst_ovf_q32", 64'(ovf_q), 64'd0);
      check("rst_out_q13", 64'(s_out_q), 64'd0);
      #1 rst = 1'b0;

      directed("d631", 32'h631, 32'd341, 32'h786, 1'b0, 1'b0);
      directed("doct", 32'd817, 32'd0, 32'd817, 1'b0, 1'b0);
      directed("dwrap", 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
      directed("dpos", 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
      directed("dneg", 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b1);

      // asynchronous reset between edges, held across one edge
      drive(32'h631, 32'd341);
      tick();
      #2 rst = 1'b1;
      #1;
      check("arst_out_q", 64'(out_q), 64'd0);
      check("arst_cout_q", 64'(cout_q), 64'd0);
      check("arst_ovf_q", 64'(ovf_q), 64'd0);
      check("arst_out_q13", 64'(s_out_q), 64'd0);
      check("arst_out", 64'(out), 64'h786);
      @(posedge clk);
      #1;
      check("hold_out_q", 64'(out_q), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rel_out_q", 64'(out_q), 64'h786);

      for (int i = 0; i < 10000; i++) begin
         drive($urandom, (i % 8 == 0) ? ~in1 : $urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
